// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
//  - fwd_sel_t : operand source select driven to the execution-stage muxes
//  - XZR       : zero register index, never a real producer
//  - ctrl_t    : decoder control bundle, field order fixed here
//  - fwd_select: forwarding priority rule for one source operand
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // EX/MEM is checked first because it holds the most recent producer.
  function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                          input logic [4:0] ex_rd,
                                          input logic       ex_we,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_we);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (ex_we && (ex_rd != XZR) && (ex_rd == src))
      sel = FWD_EXMEM;
    else if (wb_we && (wb_rd != XZR) && (wb_rd == src))
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_stage_forwarding_unit.sv
// Combinational forwarding selects for the execution stage.
// Ports:
//  id_ex_rn, id_ex_rm     in  registered source indices of the instruction in EX
//  id_ex_alu_src          in  operand B comes from the immediate
//  ex_mem_rd/_reg_write   in  EX/MEM producer
//  mem_wb_rd/_reg_write   in  MEM/WB producer
//  forward_a, forward_b   out operand source selects
module forwarding_unit
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] id_ex_rn,
  input  logic [4:0] id_ex_rm,
  input  logic       id_ex_alu_src,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  always_comb begin
    forward_a = fwd_select(id_ex_rn, ex_mem_rd, ex_mem_reg_write,
                           mem_wb_rd, mem_wb_reg_write);
    forward_b = FWD_REG;
    // The B mux sits after the immediate select, so an immediate operand
    // must never be replaced by a forwarded value.
    if (!id_ex_alu_src)
      forward_b = fwd_select(id_ex_rm, ex_mem_rd, ex_mem_reg_write,
                             mem_wb_rd, mem_wb_reg_write);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and forwarding.
// Ports:
//  clk, rst_n                     clock, asynchronous active-low reset
//  if_id_pc/_instruction          decode-stage PC and instruction
//  read_data_1/2, sign_extend_in  decode-stage operands and immediate
//  reg2loc                        1: second source is Rt [4:0], 0: Rm [20:16]
//  alu_src..branch, alu_op        decoder controls
//  flush                          kill the instruction entering EX
//  ex_mem_*, mem_wb_*             downstream producers for forwarding
//  id_ex_*                        registered stage contents (all-zero = bubble)
//  forward_a/b                    execution-stage operand selects
//  stall                          hold PC and IF/ID this cycle
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     if_id_pc,
  input  logic [INSTR_W-1:0]    if_id_instruction,
  input  logic [DATA_W-1:0]     read_data_1,
  input  logic [DATA_W-1:0]     read_data_2,
  input  logic [DATA_W-1:0]     sign_extend_in,
  input  logic                  reg2loc,
  input  logic                  alu_src,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic                  branch,
  input  logic [1:0]            alu_op,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  output logic [DATA_W-1:0]     id_ex_pc,
  output logic [DATA_W-1:0]     id_ex_read_data_1,
  output logic [DATA_W-1:0]     id_ex_read_data_2,
  output logic [DATA_W-1:0]     id_ex_sign_extend,
  output logic [INSTR_W-1:0]    id_ex_instruction,
  output logic [REG_ADDR_W-1:0] id_ex_rn,
  output logic [REG_ADDR_W-1:0] id_ex_rm,
  output logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic                  id_ex_alu_src,
  output logic                  id_ex_mem_read,
  output logic                  id_ex_mem_write,
  output logic                  id_ex_reg_write,
  output logic                  id_ex_mem_to_reg,
  output logic                  id_ex_branch,
  output logic [1:0]            id_ex_alu_op,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall
);

  logic [REG_ADDR_W-1:0] rn, rm_sel, rd;
  logic                  haz;
  ctrl_t                 ctrl_in, ctrl_q;

  assign rn      = if_id_instruction[9:5];
  assign rm_sel  = reg2loc ? if_id_instruction[4:0] : if_id_instruction[20:16];
  assign rd      = if_id_instruction[4:0];
  assign ctrl_in = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, alu_op};

  assign haz   = id_ex_mem_read && (id_ex_rd != XZR) &&
                 ((id_ex_rd == rn) || (id_ex_rd == rm_sel));
  // A flushed IF/ID instruction is wrong-path, so it must not hold the PC.
  assign stall = haz && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_pc          <= '0;
      id_ex_read_data_1 <= '0;
      id_ex_read_data_2 <= '0;
      id_ex_sign_extend <= '0;
      id_ex_instruction <= '0;
      id_ex_rn          <= '0;
      id_ex_rm          <= '0;
      id_ex_rd          <= '0;
      ctrl_q            <= '0;
    end else if (flush) begin
      id_ex_pc          <= '0;
      id_ex_read_data_1 <= '0;
      id_ex_read_data_2 <= '0;
      id_ex_sign_extend <= '0;
      id_ex_instruction <= '0;
      id_ex_rn          <= '0;
      id_ex_rm          <= '0;
      id_ex_rd          <= '0;
      ctrl_q            <= '0;
    end else begin
      // Data fields load even on a bubble; only the controls are squashed.
      id_ex_pc          <= if_id_pc;
      id_ex_read_data_1 <= read_data_1;
      id_ex_read_data_2 <= read_data_2;
      id_ex_sign_extend <= sign_extend_in;
      id_ex_instruction <= if_id_instruction;
      id_ex_rn          <= rn;
      id_ex_rm          <= rm_sel;
      id_ex_rd          <= rd;
      ctrl_q            <= haz ? '0 : ctrl_in;
    end
  end

  assign id_ex_alu_src    = ctrl_q.alu_src;
  assign id_ex_mem_read   = ctrl_q.mem_read;
  assign id_ex_mem_write  = ctrl_q.mem_write;
  assign id_ex_reg_write  = ctrl_q.reg_write;
  assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_ex_branch     = ctrl_q.branch;
  assign id_ex_alu_op     = ctrl_q.alu_op;

  forwarding_unit u_fwd (
    .id_ex_rn         (id_ex_rn),
    .id_ex_rm         (id_ex_rm),
    .id_ex_alu_src    (id_ex_alu_src),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .forward_a        (forward_a),
    .forward_b        (forward_b)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage. Each stimulus row is applied
// just after a rising edge and pushes the values expected mid-cycle; the
// monitor pops and compares on the falling edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = '0, rd1 = '0, rd2 = '0, sext = '0;
  logic [31:0] ins = '0;
  logic        reg2loc = 1'b0, flush = 1'b0;
  logic        alu_src = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        reg_write = 1'b0, mem_to_reg = 1'b0, branch = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [4:0]  ex_mem_rd = '0, mem_wb_rd = '0;
  logic        ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;

  logic [63:0] o_pc, o_rd1, o_rd2, o_sext;
  logic [31:0] o_ins;
  logic [4:0]  o_rn, o_rm, o_rd;
  logic        o_as, o_mr, o_mw, o_rw, o_mtr, o_br, o_stall;
  logic [1:0]  o_op, o_fa, o_fb;

  id_ex_stage #(.DATA_W(64), .INSTR_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_pc(pc), .if_id_instruction(ins),
    .read_data_1(rd1), .read_data_2(rd2), .sign_extend_in(sext),
    .reg2loc(reg2loc), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .alu_op(alu_op), .flush(flush),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .id_ex_pc(o_pc), .id_ex_read_data_1(o_rd1), .id_ex_read_data_2(o_rd2),
    .id_ex_sign_extend(o_sext), .id_ex_instruction(o_ins),
    .id_ex_rn(o_rn), .id_ex_rm(o_rm), .id_ex_rd(o_rd),
    .id_ex_alu_src(o_as), .id_ex_mem_read(o_mr), .id_ex_mem_write(o_mw),
    .id_ex_reg_write(o_rw), .id_ex_mem_to_reg(o_mtr), .id_ex_branch(o_br),
    .id_ex_alu_op(o_op), .forward_a(o_fa), .forward_b(o_fb), .stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        stall;
    logic [1:0]  fa, fb;
    logic [4:0]  rn, rm, rd;
    logic [7:0]  ctrl;
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Operand data is tied to the PC so the data path is checked too.
  function automatic logic [63:0] dv(input logic [63:0] p, input int k);
    return (p == 64'd0) ? 64'd0 : p + 64'(k);
  endfunction

  function automatic logic [31:0] enc(input logic [10:0] op, input logic [4:0] f,
                                      input logic [4:0] r_n, input logic [4:0] r_d);
    return {op, f, 6'd0, r_n, r_d};
  endfunction

  task automatic chk(input string nm, input string f,
                     input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, f, got, want);
    end
  endtask

  // rst_act: 0 leave reset alone, 1 assert mid-cycle, 2 release mid-cycle
  task automatic row(input string nm, input logic [31:0] i_ins, input logic i_r2l,
                     input logic [7:0] i_ctrl, input logic i_flush,
                     input logic [4:0] i_exrd, input logic i_exwe,
                     input logic [4:0] i_wbrd, input logic i_wbwe,
                     input logic [63:0] i_pc, input int rst_act,
                     input logic e_stall, input logic [1:0] e_fa, input logic [1:0] e_fb,
                     input logic [4:0] e_rn, input logic [4:0] e_rm, input logic [4:0] e_rd,
                     input logic [7:0] e_ctrl, input logic [63:0] e_pc,
                     input logic [31:0] e_ins);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_act == 1) rst_n = 1'b0;
    if (rst_act == 2) rst_n = 1'b1;
    ins = i_ins; reg2loc = i_r2l; flush = i_flush; pc = i_pc;
    {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, alu_op} = i_ctrl;
    rd1 = dv(i_pc, 1); rd2 = dv(i_pc, 2); sext = dv(i_pc, 3);
    ex_mem_rd = i_exrd; ex_mem_reg_write = i_exwe;
    mem_wb_rd = i_wbrd; mem_wb_reg_write = i_wbwe;
    e.nm = nm; e.stall = e_stall; e.fa = e_fa; e.fb = e_fb;
    e.rn = e_rn; e.rm = e_rm; e.rd = e_rd; e.ctrl = e_ctrl; e.pc = e_pc; e.ins = e_ins;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "stall", 64'(o_stall), 64'(e.stall));
        chk(e.nm, "forward_a", 64'(o_fa), 64'(e.fa));
        chk(e.nm, "forward_b", 64'(o_fb), 64'(e.fb));
        chk(e.nm, "rn", 64'(o_rn), 64'(e.rn));
        chk(e.nm, "rm", 64'(o_rm), 64'(e.rm));
        chk(e.nm, "rd", 64'(o_rd), 64'(e.rd));
        chk(e.nm, "ctrl", 64'({o_as, o_mr, o_mw, o_rw, o_mtr, o_br, o_op}), 64'(e.ctrl));
        chk(e.nm, "pc", o_pc, e.pc);
        chk(e.nm, "instr", 64'(o_ins), 64'(e.ins));
        chk(e.nm, "rd1", o_rd1, dv(e.pc, 1));
        chk(e.nm, "rd2", o_rd2, dv(e.pc, 2));
        chk(e.nm, "sext", o_sext, dv(e.pc, 3));
      end
    end
  end

  // Control bytes {alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch,alu_op}
  localparam logic [7:0] C_LD = 8'hD8, C_R = 8'h12, C_I = 8'h92, C_ST = 8'hA0;

  initial begin : stim
    logic [31:0] ld2, add3, add5, sub6, orr10, addi8, stur9, add11, ld12, sub13, add14, add15;
    ld2   = enc(11'h7C2, 5'd0, 5'd1, 5'd2);
    add3  = enc(11'h458, 5'd4, 5'd2, 5'd3);
    add5  = enc(11'h458, 5'd1, 5'd1, 5'd5);
    sub6  = enc(11'h658, 5'd5, 5'd5, 5'd6);
    orr10 = enc(11'h550, 5'd8, 5'd7, 5'd10);
    addi8 = enc(11'h488, 5'd5, 5'd5, 5'd8);
    stur9 = enc(11'h7C0, 5'd0, 5'd10, 5'd9);
    add11 = enc(11'h458, 5'd7, 5'd31, 5'd11);
    ld12  = enc(11'h7C2, 5'd0, 5'd1, 5'd12);
    sub13 = enc(11'h658, 5'd2, 5'd12, 5'd13);
    add14 = enc(11'h458, 5'd2, 5'd1, 5'd14);
    add15 = enc(11'h458, 5'd2, 5'd1, 5'd15);
    #12 rst_n = 1'b1;
    //   name       instr  r2l ctrl fl exrd we wbrd we  pc   rst  stl fa     fb     rn  rm  rd  ctrl  pc     instr
    row("reset",    ld2,   1, C_LD, 0, 0,  0, 0,  0, 'h100, 0,  0, 2'b00, 2'b00, 0,  0,  0,  8'h0, 0,     0);
    row("ldu_haz",  add3,  0, C_R,  0, 0,  0, 0,  0, 'h104, 0,  1, 2'b00, 2'b00, 1,  2,  2,  C_LD, 'h100, ld2);
    row("bubble",   add3,  0, C_R,  0, 2,  1, 0,  0, 'h104, 0,  0, 2'b10, 2'b00, 2,  4,  3,  8'h0, 'h104, add3);
    row("ldu_fwd",  add5,  0, C_R,  0, 0,  0, 2,  1, 'h108, 0,  0, 2'b01, 2'b00, 2,  4,  3,  C_R,  'h104, add3);
    row("add5",     sub6,  0, C_R,  0, 3,  1, 0,  0, 'h10C, 0,  0, 2'b00, 2'b00, 1,  1,  5,  C_R,  'h108, add5);
    row("b2b_fwd",  orr10, 0, C_R,  0, 5,  1, 3,  1, 'h110, 0,  0, 2'b10, 2'b10, 5,  5,  6,  C_R,  'h10C, sub6);
    row("ex_prio",  addi8, 0, C_I,  0, 7,  1, 7,  1, 'h114, 0,  0, 2'b10, 2'b00, 7,  8,  10, C_R,  'h110, orr10);
    row("imm_b",    stur9, 1, C_ST, 0, 5,  1, 6,  0, 'h118, 0,  0, 2'b10, 2'b00, 5,  5,  8,  C_I,  'h114, addi8);
    row("stur_rm",  add11, 0, C_R,  0, 10, 0, 9,  1, 'h11C, 0,  0, 2'b00, 2'b00, 10, 9,  9,  C_ST, 'h118, stur9);
    row("xzr",      ld12,  1, C_LD, 0, 31, 1, 7,  1, 'h120, 0,  0, 2'b00, 2'b01, 31, 7,  11, C_R,  'h11C, add11);
    row("flush_hz", sub13, 0, C_R,  1, 0,  0, 0,  0, 'h124, 0,  0, 2'b00, 2'b00, 1,  12, 12, C_LD, 'h120, ld12);
    row("flushed",  add14, 0, C_R,  0, 0,  0, 0,  0, 'h128, 0,  0, 2'b00, 2'b00, 0,  0,  0,  8'h0, 0,     0);
    row("post_fl",  add14, 0, C_R,  0, 0,  0, 0,  0, 'h128, 0,  0, 2'b00, 2'b00, 1,  2,  14, C_R,  'h128, add14);
    row("async_rst",ld12,  1, C_LD, 0, 0,  0, 0,  0, 'h12C, 1,  0, 2'b00, 2'b00, 0,  0,  0,  8'h0, 0,     0);
    row("rst_rel",  add15, 0, C_R,  0, 0,  0, 0,  0, 'h130, 2,  0, 2'b00, 2'b00, 0,  0,  0,  8'h0, 0,     0);
    row("first_ld", 32'd0, 0, 8'h0, 0, 0,  0, 0,  0, 0,     0,  0, 2'b00, 2'b00, 1,  2,  15, C_R,  'h130, add15);
    repeat (3) @(negedge clk);
    chk("end", "sb_empty", 64'(sb.size()), 64'd0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
